fetch_decode_reg: RTL and testbench
===================================

Name: fetch_decode_reg

Overview:
- IF/ID pipeline register between the fetch stage and the decode stage.
- Captures the fetch stage's PC+2 and instruction each cycle. Holds them on a stall. Replaces them with NOP bubbles on a branch/jump flush.
- Detects HALT (opcode 00000) entering decode, then freezes the pipe front end and drives the halt request back to fetch, which gates the instruction memory enable.

Parameters:
- NOP_INSTR, 16'h0800, encoding inserted as a bubble (WISC-SP13 NOP, opcode 00001).
- HALT_OPCODE, 5'b00000, Instr[15:11] value that is treated as HALT.
- FLUSH_CYCLES, 1, number of bubbles inserted per flush. Legal range 1..3; the counter is 2 bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCInc_In_FromF  in  16  PC+2 from fetch.
- Instr_In_FromF  in  16  instruction word from fetch.
- Stall_In  in  1  hazard-unit stall; equals the inverse of fetch's PCWrite.
- Flush_In  in  1  branch/jump taken in decode; equals fetch's PCsel.
- PCInc_Out_ToD  out  16  registered PC+2 to decode.
- Instr_Out_ToD  out  16  registered instruction to decode.
- Valid_Out_ToD  out  1  1 = real instruction, 0 = bubble.
- Halt_Out_ToF  out  1  registered halt request to fetch.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - PCInc_Out_ToD=0, Instr_Out_ToD=NOP_INSTR, Valid_Out_ToD=0, Halt_Out_ToF=0, err=0.
  - state=RUN, flush counter=0.
  - Reset asserted mid-flush or while HALTED fully aborts; no residue remains.
- State RUN, evaluated in priority order each clk edge:
  - Flush_In=1: load NOP_INSTR, Valid=0, PCInc_Out unchanged. Flush has priority over stall. If FLUSH_CYCLES>1, load counter with FLUSH_CYCLES-1 and go to FLUSH.
  - else Stall_In=1: hold all outputs.
  - else: load PCInc_In_FromF and Instr_In_FromF, Valid=1. If Instr_In_FromF[15:11]==HALT_OPCODE, go to HALTED.
- State FLUSH:
  - Flush_In=1: reload counter with FLUSH_CYCLES-1 and load NOP.
  - else Stall_In=1: hold outputs and counter.
  - else: load NOP, Valid=0, decrement counter; go to RUN when the counter reaches 0.
  - An instruction word seen in FLUSH is never captured and never triggers HALT.
- State HALTED:
  - Halt_Out_ToF=1 on the edge that enters HALTED; one-cycle latency from HALT capture.
  - Registers hold the HALT instruction with Valid=1.
  - Stall_In and Flush_In are ignored. Only reset leaves HALTED.
- err:
  - Set (sticky until reset) when Flush_In=1 arrives while HALTED.
  - Set when Flush_In=1 and Stall_In=1 arrive together with Valid_Out_ToD=0; a bubble cannot resolve a branch.
  - Outputs are unaffected by err.
- Outputs are purely registered; no combinational path from any input to any output.

Optional Feature:
- Macro: FD_PERF_CNT_EN.
- Defined: adds output ports StallCnt_Out [15:0] and BubbleCnt_Out [15:0].
  - StallCnt_Out increments on each edge where a stall holds in RUN or FLUSH.
  - BubbleCnt_Out increments on each NOP load.
  - Both saturate at 16'hFFFF, reset to 0, and freeze in HALTED.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include file fd_defs:
  - state encoding: RUN=2'b00, FLUSH=2'b01, HALTED=2'b10.
  - constants: NOP_INSTR, HALT_OPCODE.
- Sub-module fd_ctrl: next-state logic and flush counter.
- Datapath registers built from the codebase's dff cells with load-enable muxes.

Test Plan:
- Reset then stream: Instr 16'h4123/PC 2, 16'h4124/PC 4, no stall/flush. Each appears one cycle later with Valid=1; Instr_Out=16'h0800 and Valid=0 during reset.
- Stall_In=1 for 3 cycles while fetch presents 16'h4125. Outputs hold the prior 16'h4124/PC 4 for 3 cycles, then 16'h4125 loads.
- Flush_In=1 with Stall_In=1, Valid_Out=1, FLUSH_CYCLES=1. Next cycle Instr_Out=16'h0800, Valid=0, PCInc unchanged, err stays 0.
- FLUSH_CYCLES=2, flush, then a stall in the bubble cycle. Exactly 2 NOPs are loaded, the stall stretches the FLUSH state, then normal capture resumes.
- Fetch presents 16'h0000 unstalled. Next edge Halt_Out_ToF=1 and Instr_Out=16'h0000. Later Flush_In=1 sets err=1 and outputs are unchanged. rst=0 clears everything asynchronously mid-cycle.
- FD_PERF_CNT_EN defined: 5 stalls and 3 flushes give StallCnt=5 and BubbleCnt=3. A forced 70000-stall run saturates StallCnt at 16'hFFFF.

Source files
------------

// File: rtl/fd_defs.sv
// fd_defs: shared state encoding and instruction constants for the IF/ID
// pipeline register (fetch_decode_reg) and its control block.
package fd_defs;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    HALTED = 2'b10
  } fd_state_t;

  // WISC-SP13 NOP (opcode 00001), loaded as a bubble
  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  // Instr[15:11] value that stops the front end
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  function automatic logic is_halt(input logic [4:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/dff.sv
// dff: D flip-flop cell with load enable and asynchronous active-low reset.
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold; reset forces RST_VAL immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fd_ctrl.sv
// fd_ctrl: RUN/FLUSH/HALTED sequencing and flush bubble counter for the
// IF/ID register. Produces the datapath load strobes.
module fd_ctrl
  import fd_defs::*;
#(
  parameter int FLUSH_CYCLES = 1  // bubbles per flush, 1..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall,
  input  logic [4:0] opcode,
  output logic       halted,
  output logic       cap_en,    // capture fetch PC+2 and instruction
  output logic       nop_en,    // load a NOP bubble
  output logic       halt_set   // HALT captured this edge
);

  localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

  fd_state_t  state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;

  // State and flush counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, counter update and load strobes; flush outranks stall
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cap_en     = 1'b0;
    nop_en     = 1'b0;
    halt_set   = 1'b0;
    case (state_reg)
      RUN: begin
        if (flush) begin
          nop_en = 1'b1;
          if (RELOAD != 2'd0) begin
            cnt_next   = RELOAD;
            state_next = FLUSH;
          end
        end else if (!stall) begin
          cap_en = 1'b1;
          if (is_halt(opcode)) begin
            halt_set   = 1'b1;
            state_next = HALTED;
          end
        end
      end
      FLUSH: begin
        // Instructions presented here are never captured
        if (flush) begin
          nop_en   = 1'b1;
          cnt_next = RELOAD;
          if (RELOAD == 2'd0) begin
            state_next = RUN;
          end
        end else if (!stall) begin
          nop_en = 1'b1;
          if (cnt_reg <= 2'd1) begin
            cnt_next   = 2'd0;
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
      end
      HALTED: begin
        // Only reset leaves HALTED
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
        cnt_next   = 2'd0;
      end
    endcase
  end

  assign halted = (state_reg == HALTED);

endmodule

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID pipeline register. Captures PC+2 and the
// instruction, holds on stall, inserts NOP bubbles on flush, and freezes the
// front end once a HALT reaches decode.
// Optional macro FD_PERF_CNT_EN adds saturating stall/bubble counters.
module fetch_decode_reg
  import fd_defs::*;
#(
  parameter int FLUSH_CYCLES = 1  // bubbles per flush, 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PCInc_In_FromF,
  input  logic [15:0] Instr_In_FromF,
  input  logic        Stall_In,
  input  logic        Flush_In,
  output logic [15:0] PCInc_Out_ToD,
  output logic [15:0] Instr_Out_ToD,
  output logic        Valid_Out_ToD,
  output logic        Halt_Out_ToF,
  output logic        err
`ifdef FD_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt_Out,
  output logic [15:0] BubbleCnt_Out
`endif
);

  logic        halted, cap_en, nop_en, halt_set;
  logic        data_en, err_set;
  logic [15:0] pc_reg, instr_reg, instr_next;
  logic        valid_reg, halt_reg, err_reg;

  fd_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .flush    (Flush_In),
    .stall    (Stall_In),
    .opcode   (Instr_In_FromF[15:11]),
    .halted   (halted),
    .cap_en   (cap_en),
    .nop_en   (nop_en),
    .halt_set (halt_set)
  );

  assign data_en    = cap_en | nop_en;
  assign instr_next = nop_en ? NOP_INSTR : Instr_In_FromF;

  // A flush while halted, or a flush+stall on a bubble, is a protocol error
  assign err_set = Flush_In & (halted | (Stall_In & ~valid_reg));

  // Instruction register built per bit so each bit resets to the NOP encoding
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_instr_bit
      dff #(.WIDTH(1), .RST_VAL(NOP_INSTR[gi])) u_instr_bit (
        .clk (clk), .rst (rst), .en (data_en),
        .d   (instr_next[gi]), .q (instr_reg[gi])
      );
    end
  endgenerate

  // PC+2 is only updated by a real capture; bubbles keep the last value
  dff #(.WIDTH(16), .RST_VAL(16'h0000)) u_pc (
    .clk (clk), .rst (rst), .en (cap_en), .d (PCInc_In_FromF), .q (pc_reg)
  );

  dff #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
    .clk (clk), .rst (rst), .en (data_en), .d (cap_en), .q (valid_reg)
  );

  // Halt request rises on the same edge that captures the HALT
  dff #(.WIDTH(1), .RST_VAL(1'b0)) u_halt (
    .clk (clk), .rst (rst), .en (halt_set), .d (1'b1), .q (halt_reg)
  );

  dff #(.WIDTH(1), .RST_VAL(1'b0)) u_err (
    .clk (clk), .rst (rst), .en (err_set), .d (1'b1), .q (err_reg)
  );

  assign PCInc_Out_ToD = pc_reg;
  assign Instr_Out_ToD = instr_reg;
  assign Valid_Out_ToD = valid_reg;
  assign Halt_Out_ToF  = halt_reg;
  assign err           = err_reg;

`ifdef FD_PERF_CNT_EN
  logic        stall_hold;
  logic [15:0] stall_cnt_reg, bubble_cnt_reg;

  // A stall holds only when no flush overrides it and the pipe is not halted
  assign stall_hold = ~halted & ~Flush_In & Stall_In;

  // Saturating event counters; both are idle in HALTED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg  <= 16'd0;
      bubble_cnt_reg <= 16'd0;
    end else begin
      if (stall_hold && stall_cnt_reg != 16'hFFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (nop_en && bubble_cnt_reg != 16'hFFFF) begin
        bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end
    end
  end

  assign StallCnt_Out  = stall_cnt_reg;
  assign BubbleCnt_Out = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed self-checking bench for fetch_decode_reg.
// dut uses one bubble per flush, dut2 uses two; both see the same stimulus.
module tb_fetch_decode_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in, instr_in;
  logic        stall, flush;

  logic [15:0] pc_out, instr_out, pc_out2, instr_out2;
  logic        valid_out, halt_out, err_out;
  logic        valid_out2, halt_out2, err_out2;
`ifdef FD_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt, stall_cnt2, bubble_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_reg #(.FLUSH_CYCLES(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCInc_In_FromF (pc_in),
    .Instr_In_FromF (instr_in),
    .Stall_In       (stall),
    .Flush_In       (flush),
    .PCInc_Out_ToD  (pc_out),
    .Instr_Out_ToD  (instr_out),
    .Valid_Out_ToD  (valid_out),
    .Halt_Out_ToF   (halt_out),
    .err            (err_out)
`ifdef FD_PERF_CNT_EN
    ,
    .StallCnt_Out   (stall_cnt),
    .BubbleCnt_Out  (bubble_cnt)
`endif
  );

  fetch_decode_reg #(.FLUSH_CYCLES(2)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .PCInc_In_FromF (pc_in),
    .Instr_In_FromF (instr_in),
    .Stall_In       (stall),
    .Flush_In       (flush),
    .PCInc_Out_ToD  (pc_out2),
    .Instr_Out_ToD  (instr_out2),
    .Valid_Out_ToD  (valid_out2),
    .Halt_Out_ToF   (halt_out2),
    .err            (err_out2)
`ifdef FD_PERF_CNT_EN
    ,
    .StallCnt_Out   (stall_cnt2),
    .BubbleCnt_Out  (bubble_cnt2)
`endif
  );

  // One clock edge, sampled 1 time unit later; prints one line per transaction
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t in pc=%h ins=%h st=%b fl=%b | out pc=%h ins=%h v=%b h=%b e=%b | dut2 ins=%h v=%b",
             $time, pc_in, instr_in, stall, flush, pc_out, instr_out, valid_out,
             halt_out, err_out, instr_out2, valid_out2);
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] ins,
                       input logic st, input logic fl);
    pc_in = pc; instr_in = ins; stall = st; flush = fl;
  endtask

  task automatic do_reset();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    #12;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc_out); end
    checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h expected 0800", instr_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_out); end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    drive(16'd2, 16'h4123, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out !== 16'h4123) begin errors++; $display("FAIL stream0_instr: got %h expected 4123", instr_out); end
    checks++; if (pc_out !== 16'd2) begin errors++; $display("FAIL stream0_pc: got %h expected 0002", pc_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream0_valid: got %b expected 1", valid_out); end
    drive(16'd4, 16'h4124, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out !== 16'h4124) begin errors++; $display("FAIL stream1_instr: got %h expected 4124", instr_out); end
    checks++; if (pc_out !== 16'd4) begin errors++; $display("FAIL stream1_pc: got %h expected 0004", pc_out); end
  endtask

  task automatic test_stall();
    drive(16'd6, 16'h4125, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_out !== 16'h4124) begin errors++; $display("FAIL stall_hold_instr[%0d]: got %h expected 4124", i, instr_out); end
      checks++; if (pc_out !== 16'd4) begin errors++; $display("FAIL stall_hold_pc[%0d]: got %h expected 0004", i, pc_out); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d]: got %b expected 1", i, valid_out); end
    end
    stall = 1'b0;
    tick();
    checks++; if (instr_out !== 16'h4125) begin errors++; $display("FAIL stall_release_instr: got %h expected 4125", instr_out); end
    checks++; if (pc_out !== 16'd6) begin errors++; $display("FAIL stall_release_pc: got %h expected 0006", pc_out); end
  endtask

  task automatic test_flush_stall();
    // Valid=1 in decode, so flush+stall together is legal
    drive(16'd8, 16'h4126, 1'b1, 1'b1);
    tick();
    checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL flush_instr: got %h expected 0800", instr_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", valid_out); end
    checks++; if (pc_out !== 16'd6) begin errors++; $display("FAIL flush_pc: got %h expected 0006", pc_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", err_out); end
    drive(16'd8, 16'h4126, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out !== 16'h4126) begin errors++; $display("FAIL flush_resume_instr: got %h expected 4126", instr_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL flush_resume_valid: got %b expected 1", valid_out); end
  endtask

  task automatic test_flush2();
    do_reset();
    drive(16'd10, 16'h4130, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out2 !== 16'h4130) begin errors++; $display("FAIL f2_capture: got %h expected 4130", instr_out2); end
    drive(16'd12, 16'h4131, 1'b0, 1'b1);
    tick();
    checks++; if (instr_out2 !== 16'h0800) begin errors++; $display("FAIL f2_nop1_instr: got %h expected 0800", instr_out2); end
    checks++; if (valid_out2 !== 1'b0) begin errors++; $display("FAIL f2_nop1_valid: got %b expected 0", valid_out2); end
    checks++; if (pc_out2 !== 16'd10) begin errors++; $display("FAIL f2_nop1_pc: got %h expected 000a", pc_out2); end
    // Stall during the bubble stretches FLUSH
    drive(16'd12, 16'h4131, 1'b1, 1'b0);
    tick();
    tick();
    checks++; if (instr_out2 !== 16'h0800) begin errors++; $display("FAIL f2_stretch_instr: got %h expected 0800", instr_out2); end
    checks++; if (valid_out2 !== 1'b0) begin errors++; $display("FAIL f2_stretch_valid: got %b expected 0", valid_out2); end
    // Second bubble; a HALT word seen in FLUSH must be ignored
    drive(16'd12, 16'h0000, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out2 !== 16'h0800) begin errors++; $display("FAIL f2_nop2_instr: got %h expected 0800", instr_out2); end
    checks++; if (halt_out2 !== 1'b0) begin errors++; $display("FAIL f2_nop2_halt: got %b expected 0", halt_out2); end
    drive(16'd14, 16'h4131, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out2 !== 16'h4131) begin errors++; $display("FAIL f2_resume_instr: got %h expected 4131", instr_out2); end
    checks++; if (pc_out2 !== 16'd14) begin errors++; $display("FAIL f2_resume_pc: got %h expected 000e", pc_out2); end
    checks++; if (err_out2 !== 1'b0) begin errors++; $display("FAIL f2_err: got %b expected 0", err_out2); end
  endtask

  task automatic test_err_bubble();
    do_reset();
    // Decode holds the reset bubble (Valid=0)
    drive(16'd2, 16'h4140, 1'b1, 1'b1);
    tick();
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_bubble: got %b expected 1", err_out); end
    drive(16'd2, 16'h4140, 1'b0, 1'b0);
    tick();
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_out); end
    checks++; if (instr_out !== 16'h4140) begin errors++; $display("FAIL err_no_effect: got %h expected 4140", instr_out); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(16'd2, 16'h4150, 1'b0, 1'b0);
    tick();
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halt_out); end
    drive(16'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_req: got %b expected 1", halt_out); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL halt_instr: got %h expected 0000", instr_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL halt_valid: got %b expected 1", valid_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL halt_err0: got %b expected 0", err_out); end
    drive(16'd6, 16'h4151, 1'b0, 1'b1);
    tick();
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL halt_flush_err: got %b expected 1", err_out); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL halt_flush_instr: got %h expected 0000", instr_out); end
    checks++; if (pc_out !== 16'd4) begin errors++; $display("FAIL halt_flush_pc: got %h expected 0004", pc_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL halt_flush_valid: got %b expected 1", valid_out); end
    drive(16'd8, 16'h4152, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL halt_frozen_instr: got %h expected 0000", instr_out); end
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_frozen_req: got %b expected 1", halt_out); end
    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL async_halt: got %b expected 0", halt_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err_out); end
    checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL async_instr: got %h expected 0800", instr_out); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL async_pc: got %h expected 0000", pc_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", valid_out); end
    #1;
    rst = 1'b1;
    // Back in RUN after reset: capture works again
    drive(16'd10, 16'h4153, 1'b0, 1'b0);
    tick();
    checks++; if (instr_out !== 16'h4153) begin errors++; $display("FAIL post_reset_capture: got %h expected 4153", instr_out); end
  endtask

`ifdef FD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    drive(16'd2, 16'h4160, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(16'd2, 16'h4160, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
    checks++; if (bubble_cnt !== 16'd3) begin errors++; $display("FAIL perf_bubble: got %0d expected 3", bubble_cnt); end
    drive(16'd2, 16'h4160, 1'b1, 1'b0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %h expected ffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_flush2();
    test_err_bubble();
    test_halt();
`ifdef FD_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
